// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds the FSM state encoding, the default range limit and the fixed
// codes loaded for out-of-range inputs.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int          BCD_MAX_DEFAULT = 9999;
  localparam logic [15:0] BCD_ERR         = 16'hEEEE;
  localparam logic [15:0] BCD_SAT         = 16'h9999;
  localparam int          NDIG            = 4;

endpackage

// File: rtl/module_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decade.
// The result never exceeds 4'hC, so a plain 4-bit add is sufficient.
module module_bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/module_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Feeds the display controller; bcd and ovf only change when a conversion
// completes, so the display never shows intermediate digits.
// Build option: define BIN2BCD_SATURATE_EN to load 16'h9999 for out-of-range
// inputs instead of the 16'hEEEE error pattern.
module module_bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int BCD_MAX  = BCD_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic [15:0]         bcd,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);

`ifdef BIN2BCD_SATURATE_EN
  localparam logic [15:0] OOR_CODE = BCD_SAT;
`else
  localparam logic [15:0] OOR_CODE = BCD_ERR;
`endif

  state_e              state_q,   state_d;
  logic [IN_WIDTH-1:0] shreg_q,   shreg_d;
  logic [15:0]         scratch_q, scratch_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                range_q,   range_d;
  logic [15:0]         bcd_q,     bcd_d;
  logic                done_q,    done_d;
  logic                ovf_q,     ovf_d;

  logic [15:0]         adj;
  logic [31:0]         binExt;
  logic                outOfRange;

  // Zero-extend the input so the range test works for any IN_WIDTH.
  assign binExt     = 32'(bin_in);
  assign outOfRange = (binExt > $unsigned(BCD_MAX));

  // Four independent nibble correctors on the scratch register.
  for (genvar g = 0; g < NDIG; g++) begin : gDigit
    module_bcd_digit_adj uAdj (
      .digit_i(scratch_q[4*g +: 4]),
      .digit_o(adj[4*g +: 4])
    );
  end

  // Next-state and datapath: capture in IDLE, adjust-and-shift in SHIFT,
  // publish the result in LOAD.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    range_d   = range_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin_in;
          scratch_d = '0;
          range_d   = outOfRange;
          cnt_d     = CNT_W'(IN_WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        busy                 = 1'b1;
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        cnt_d                = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        bcd_d   = range_q ? OOR_CODE : scratch_q;
        ovf_d   = range_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers; reset discards any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      range_q   <= 1'b0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      range_q   <= range_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_module_bin2bcd.sv
// Directed testbench for module_bin2bcd: reset, basic conversion and latency,
// range boundaries, start handshake and asynchronous reset mid-conversion.
// Expected out-of-range code follows BIN2BCD_SATURATE_EN when defined.
module tb_module_bin2bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [15:0] expOor;

  module_bin2bcd #(.IN_WIDTH(14), .BCD_MAX(9999)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin_in(bin_in),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Present a start request for one edge; afterwards we sit 1 ns past that edge.
  task automatic applyStimulus(input logic [13:0] value);
    start  = 1'b1;
    bin_in = value;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = 14'h3FFF;
  endtask

  // Count edges until done is seen (bounded); -1 means it never came.
  task automatic waitDone(output int cycles, output int busyCount);
    cycles    = 0;
    busyCount = 0;
    while (!done && cycles < 40) begin
      if (busy) busyCount++;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    #10;
    testsRun++;
    if ({bcd, busy, done, ovf} !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got bcd=%h busy=%b done=%b ovf=%b, expected all zero", bcd, busy, done, ovf);
    end
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    testsRun++;
    if ({bcd, busy, done, ovf} !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_idle: got bcd=%h busy=%b done=%b ovf=%b, expected all zero", bcd, busy, done, ovf);
    end
  endtask

  task automatic test_basic();
    int lat, busyCnt;
    applyStimulus(14'd1234);
    waitDone(lat, busyCnt);
    testsRun++;
    if (lat !== 15) begin
      testsFailed++;
      $display("[TB] FAIL basic_latency: got %0d cycles, expected 15", lat);
    end
    testsRun++;
    if (bcd !== 16'h1234) begin
      testsFailed++;
      $display("[TB] FAIL basic_bcd: got %h, expected 1234", bcd);
    end
    testsRun++;
    if (ovf !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_ovf: got %b, expected 0", ovf);
    end
    testsRun++;
    if (busyCnt !== 14) begin
      testsFailed++;
      $display("[TB] FAIL basic_busy_cycles: got %0d, expected 14", busyCnt);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (done !== 1'b0 || bcd !== 16'h1234) begin
      testsFailed++;
      $display("[TB] FAIL basic_done_pulse: got done=%b bcd=%h, expected done=0 bcd=1234", done, bcd);
    end
  endtask

  task automatic test_range();
    logic [13:0] vals   [4];
    logic [15:0] expBcd [4];
    logic        expOvf [4];
    logic        prevOvf;
    int          lat, busyCnt;
    vals = '{14'd0, 14'd9999, 14'd10000, 14'd5};
    expBcd = '{16'h0000, 16'h9999, expOor, 16'h0005};
    expOvf = '{1'b0, 1'b0, 1'b1, 1'b0};
    prevOvf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vals[i]);
      testsRun++;
      if (ovf !== prevOvf) begin
        testsFailed++;
        $display("[TB] FAIL range_ovf_hold_%0d: got %b, expected %b", vals[i], ovf, prevOvf);
      end
      waitDone(lat, busyCnt);
      testsRun++;
      if (lat !== 15 || bcd !== expBcd[i] || ovf !== expOvf[i]) begin
        testsFailed++;
        $display("[TB] FAIL range_%0d: got lat=%0d bcd=%h ovf=%b, expected lat=15 bcd=%h ovf=%b",
                 vals[i], lat, bcd, ovf, expBcd[i], expOvf[i]);
      end
      prevOvf = expOvf[i];
    end
  endtask

  task automatic test_back_to_back();
    int lat, busyCnt;
    applyStimulus(14'd5678);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(14'd4321);
    waitDone(lat, busyCnt);
    testsRun++;
    if (lat !== 10 || bcd !== 16'h5678) begin
      testsFailed++;
      $display("[TB] FAIL b2b_ignore_busy: got remaining=%0d bcd=%h, expected remaining=10 bcd=5678", lat, bcd);
    end
    applyStimulus(14'd42);
    testsRun++;
    if (busy !== 1'b1 || bcd !== 16'h5678) begin
      testsFailed++;
      $display("[TB] FAIL b2b_accept_on_done: got busy=%b bcd=%h, expected busy=1 bcd=5678", busy, bcd);
    end
    waitDone(lat, busyCnt);
    testsRun++;
    if (lat !== 15 || bcd !== 16'h0042) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: got lat=%0d bcd=%h, expected lat=15 bcd=0042", lat, bcd);
    end
  endtask

  task automatic test_reset_mid();
    int   lat, busyCnt;
    logic sawDone;
    applyStimulus(14'd8765);
    repeat (7) @(posedge clk);
    #1;
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_busy_before: got %b, expected 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    testsRun++;
    if ({bcd, busy, done, ovf} !== 19'h0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_async: got bcd=%h busy=%b done=%b ovf=%b, expected all zero", bcd, busy, done, ovf);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone !== 1'b0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_no_done: got sawDone=%b busy=%b, expected 0 0", sawDone, busy);
    end
    applyStimulus(14'd8765);
    waitDone(lat, busyCnt);
    testsRun++;
    if (lat !== 15 || bcd !== 16'h8765 || ovf !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_reconvert: got lat=%0d bcd=%h ovf=%b, expected lat=15 bcd=8765 ovf=0", lat, bcd, ovf);
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
`ifdef BIN2BCD_SATURATE_EN
    expOor = 16'h9999;
`else
    expOor = 16'hEEEE;
`endif
    test_reset();
    test_basic();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
